// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one full-subtractor step per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic             br_q, br_d, bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             d_bit, br_nxt, last;
`ifdef SERIAL_SUB_OVF_EN
   logic             sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;
`endif
   always_comb begin
      d_bit   = a_q[0] ^ b_q[0] ^ br_q;
      br_nxt  = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
      last    = cnt_q == CW'(WIDTH - 1);
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
      sa_d    = sa_q;
      sb_d    = sb_q;
      ovf_d   = ovf_q;
`endif
      if (state_q == RUN) begin
         a_d    = a_q >> 1;
         b_d    = b_q >> 1;
         br_d   = br_nxt;
         diff_d = {d_bit, diff_q[WIDTH-1:1]};
         cnt_d  = cnt_q + CW'(1);
         if (last) begin
            state_d = DONE;
            bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // d_bit of the last step is the result sign bit
            ovf_d   = (sa_q != sb_q) && (d_bit != sa_q);
`endif
         end
      end else if (start) begin
         state_d = RUN;
         a_d     = a;
         b_d     = b;
         br_d    = bin;
         cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
         sa_d    = a[WIDTH-1];
         sb_d    = b[WIDTH-1];
`endif
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ovf_q   <= ovf_d;
`endif
      end
   end
   assign busy = state_q == RUN;
   assign done = state_q == DONE;
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor (WIDTH=4)
// against an integer-arithmetic reference; ovf checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
   localparam int W = 4;
   logic         clock = 1'b0, reset = 1'b1, start = 1'b0, bin = 1'b0;
   logic [W-1:0] a = '0, b = '0, diff;
   logic         busy, done, bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif
   int           n_run = 0, n_fail = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_diff(input int ta, input int tb, input int tbin);
      int r;
      r = ta - tb - tbin;
      return (r % 16 + 16) % 16;
   endfunction

   function automatic int exp_bout(input int ta, input int tb, input int tbin);
      return (ta < tb + tbin) ? 1 : 0;
   endfunction

   function automatic int exp_ovf(input int ta, input int tb, input int tbin);
      int sa, sb, r;
      sa = ta >= 8 ? ta - 16 : ta;
      sb = tb >= 8 ? tb - 16 : tb;
      r  = sa - sb - tbin;
      return (r < -8 || r > 7) ? 1 : 0;
   endfunction

   // Called just after a negedge with the DUT idle; leaves it idle just after a negedge.
   task automatic run_op(input int ta, input int tb, input int tbin);
      int lat;
      lat = 0;
      a = 4'(ta); b = 4'(tb); bin = 1'(tbin); start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0; a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      @(negedge clock);
      check("busy_after_start", 32'(busy), 32'd1);
      while (!done && lat < 10) begin
         @(negedge clock);
         lat++;
      end
      check("latency", 32'(lat), 32'd4);
      check("busy_in_done", 32'(busy), 32'd0);
      check("diff", 32'(diff), 32'(exp_diff(ta, tb, tbin)));
      check("bout", 32'(bout), 32'(exp_bout(ta, tb, tbin)));
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", 32'(ovf), 32'(exp_ovf(ta, tb, tbin)));
`endif
      @(negedge clock);
      check("done_one_cycle", 32'(done), 32'd0);
      check("diff_hold", 32'(diff), 32'(exp_diff(ta, tb, tbin)));
   endtask

   initial begin
      int ndone, cap;
      int qa[$], qb[$], qbin[$];
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_op(9, 3, 0);
      run_op(3, 9, 0);
      run_op(0, 0, 1);
      run_op(0, 1, 0);
      run_op(15, 15, 1);
      run_op(8, 1, 0);
      run_op(7, 1, 0);
      run_op(15, 0, 0);
      // start during RUN must be ignored
      a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(posedge clock);
      #1 start = 1'b1; a = 4'd1; b = 4'd1;
      @(posedge clock);
      #1 start = 1'b0; a = 4'd5; b = 4'd12;
      ndone = 0; cap = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (done) begin
            ndone++;
            cap = 32'(diff);
         end
      end
      check("ignored_start_dones", 32'(ndone), 32'd1);
      check("ignored_start_diff", 32'(cap), 32'd6);
      // asynchronous reset mid-operation
      a = 4'd9; b = 4'd3; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_bout", 32'(bout), 32'd0);
      #1 reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      run_op(9, 3, 0);
      // start held high: a new operation every WIDTH+1 cycles
      start = 1'b1;
      a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      for (int op = 0; op < 6; op++) begin
         for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
               qa.push_back(int'(a)); qb.push_back(int'(b)); qbin.push_back(int'(bin));
            end
            @(posedge clock);
            #1 a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
            @(negedge clock);
            check("b2b_done", 32'(done), 32'(c == 4));
            if (c == 4) begin
               check("b2b_diff", 32'(diff), 32'(exp_diff(qa[0], qb[0], qbin[0])));
               check("b2b_bout", 32'(bout), 32'(exp_bout(qa[0], qb[0], qbin[0])));
`ifdef SERIAL_SUB_OVF_EN
               check("b2b_ovf", 32'(ovf), 32'(exp_ovf(qa[0], qb[0], qbin[0])));
`endif
               void'(qa.pop_front()); void'(qb.pop_front()); void'(qbin.pop_front());
            end
         end
      end
      start = 1'b0;
      @(negedge clock);
      check("b2b_idle", 32'(busy | done), 32'd0);
      for (int i = 0; i < 150; i++)
         run_op(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
